// File: rtl/seg_scan_mux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_mux_pkg                                                         |
// | Seven-segment patterns and active-low polarity constants for the scanner |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package seg_scan_mux_pkg;

    // Patterns are {g,f,e,d,c,b,a}, a 0 lights the segment
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic AN_ON  = 1'b0;
    localparam logic AN_OFF = 1'b1;
    localparam logic DP_ON  = 1'b0;
    localparam logic DP_OFF = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seg_scan_mux_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_mux_if                                                          |
// | Update bus and display pin bundle for the seven-segment scanner          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface seg_scan_mux_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] din;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank_in;
    logic                  upd;
    logic                  pending;
    logic [N_DIGITS-1:0]   an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_start;

    modport master (
        output din, dp_in, blank_in, upd,
        input  pending, an, seg, dp, frame_start
    );

    modport slave (
        input  din, dp_in, blank_in, upd,
        output pending, an, seg, dp, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_mux_hex7seg_dec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex7seg_dec                                                              |
// | Combinational hex digit to active-low seven-segment decoder              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hex7seg_dec
    import seg_scan_mux_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_digit)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_mux                                                             |
// | Double-buffered, time-multiplexed N-digit seven-segment scan driver.     |
// | Optional SEG_SCAN_LZ_BLANK_EN adds leading-zero blanking.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    seg_scan_mux_if.slave sif
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD      = PW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [4*N_DIGITS-1:0] r_act_din, r_pnd_din;
    logic [N_DIGITS-1:0]   r_act_dp, r_pnd_dp;
    logic [N_DIGITS-1:0]   r_act_blank, r_pnd_blank;
    logic                  r_pending;
    logic [N_DIGITS-1:0]   r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic                  r_frame_start;

    logic                  w_terminal;
    logic                  w_boundary;
    logic [3:0]            w_digit;
    logic [6:0]            w_seg;
    logic [N_DIGITS-1:0]   w_lz_blank;
    logic [N_DIGITS-1:0]   w_blank_vec;
    logic                  w_blank;
    logic [N_DIGITS-1:0]   w_an_sel;

    assign w_terminal = (r_presc == PRESC_LAST);
    assign w_boundary = w_terminal && (r_idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_terminal) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Active data only moves at the frame boundary; an upd landing on the
    // boundary bypasses the shadow so the newest value is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act_din   <= '0;
            r_act_dp    <= '0;
            r_act_blank <= '0;
            r_pnd_din   <= '0;
            r_pnd_dp    <= '0;
            r_pnd_blank <= '0;
            r_pending   <= 1'b0;
        end else if (w_boundary) begin
            if (sif.upd) begin
                r_act_din   <= sif.din;
                r_act_dp    <= sif.dp_in;
                r_act_blank <= sif.blank_in;
            end else if (r_pending) begin
                r_act_din   <= r_pnd_din;
                r_act_dp    <= r_pnd_dp;
                r_act_blank <= r_pnd_blank;
            end
            r_pending <= 1'b0;
        end else if (sif.upd) begin
            r_pnd_din   <= sif.din;
            r_pnd_dp    <= sif.dp_in;
            r_pnd_blank <= sif.blank_in;
            r_pending   <= 1'b1;
        end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    logic w_lz_run;

    // Zero digits from the MSB down go dark until a nonzero digit or a lit dp
    always_comb begin
        w_lz_blank = '0;
        w_lz_run   = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            w_lz_run      = w_lz_run & (r_act_din[4*i +: 4] == 4'h0) & ~r_act_dp[i];
            w_lz_blank[i] = w_lz_run;
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    assign w_blank_vec = r_act_blank | w_lz_blank;
    assign w_blank     = w_blank_vec[r_idx];
    assign w_digit     = 4'(r_act_din >> {r_idx, 2'b00});
    assign w_an_sel    = ~(N_DIGITS'(1) << r_idx);

    hex7seg_dec u_dec (
        .i_digit (w_digit),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an          <= {N_DIGITS{AN_OFF}};
            r_seg         <= SEG_OFF;
            r_dp          <= DP_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
            if (w_blank) begin
                r_an  <= {N_DIGITS{AN_OFF}};
                r_seg <= SEG_OFF;
                r_dp  <= DP_OFF;
            end else begin
                r_an  <= (r_presc < GUARD) ? {N_DIGITS{AN_OFF}} : w_an_sel;
                r_seg <= w_seg;
                r_dp  <= r_act_dp[r_idx] ? DP_ON : DP_OFF;
            end
        end
    end

    assign sif.pending     = r_pending;
    assign sif.an          = r_an;
    assign sif.seg         = r_seg;
    assign sif.dp          = r_dp;
    assign sif.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg_scan_mux                                                          |
// | Self-checking bench: cycle model of the scanner plus literal spot checks |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_seg_scan_mux;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int G     = 2;
    localparam int FRAME = N * DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    seg_scan_mux_if #(.N_DIGITS(N)) sif ();

    seg_scan_mux #(
        .N_DIGITS     (N),
        .REFRESH_DIV  (DIV),
        .GUARD_CYCLES (G)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic is_dark(input int idx, input logic [15:0] d,
                                     input logic [3:0] p, input logic [3:0] b);
        logic dark;
        dark = b[idx];
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (idx > 0) begin
            logic all_zero;
            all_zero = 1'b1;
            for (int j = idx; j < N; j++)
                if (4'(d >> (4 * j)) != 4'h0 || p[j]) all_zero = 1'b0;
            dark = dark | all_zero;
        end
`endif
        return dark;
    endfunction

    // Expected {an, seg, dp} for the k-th cycle after reset release
    function automatic logic [11:0] exp_out(input int k, input logic [15:0] d,
                                            input logic [3:0] p, input logic [3:0] b);
        int presc, idx;
        logic [3:0] an;
        presc = k % DIV;
        idx   = (k / DIV) % N;
        if (is_dark(idx, d, p, b)) return {4'hF, 7'h7F, 1'b1};
        an = (presc < G) ? 4'hF : 4'(~(4'b0001 << idx));
        return {an, seg_of(4'(d >> (4 * idx))), ~p[idx]};
    endfunction

    int          m_k = 0;
    logic [15:0] m_act_d = '0, m_pnd_d = '0;
    logic [3:0]  m_act_p = '0, m_pnd_p = '0, m_act_b = '0, m_pnd_b = '0;
    logic        m_pend = 1'b0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic        e_fs = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k <= 0; m_act_d <= '0; m_act_p <= '0; m_act_b <= '0;
            m_pnd_d <= '0; m_pnd_p <= '0; m_pnd_b <= '0; m_pend <= 1'b0;
            e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_fs <= 1'b0;
        end else begin
            {e_an, e_seg, e_dp} <= exp_out(m_k, m_act_d, m_act_p, m_act_b);
            e_fs <= (m_k % FRAME == FRAME - 1);
            if (m_k % FRAME == FRAME - 1) begin
                if (sif.upd) begin
                    m_act_d <= sif.din; m_act_p <= sif.dp_in; m_act_b <= sif.blank_in;
                end else if (m_pend) begin
                    m_act_d <= m_pnd_d; m_act_p <= m_pnd_p; m_act_b <= m_pnd_b;
                end
                m_pend <= 1'b0;
            end else if (sif.upd) begin
                m_pnd_d <= sif.din; m_pnd_p <= sif.dp_in; m_pnd_b <= sif.blank_in;
                m_pend <= 1'b1;
            end
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        check("model_an", 32'(sif.an), 32'(e_an));
        check("model_seg", 32'(sif.seg), 32'(e_seg));
        check("model_dp", 32'(sif.dp), 32'(e_dp));
        check("model_fs", 32'(sif.frame_start), 32'(e_fs));
        check("model_pending", 32'(sif.pending), 32'(m_pend));
    end

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sif.frame_start && n < 4 * FRAME);
        if (!sif.frame_start) check("fs_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_upd(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        @(negedge clk);
        sif.din = d; sif.dp_in = p; sif.blank_in = b; sif.upd = 1'b1;
        @(negedge clk);
        sif.upd = 1'b0;
    endtask

    task automatic at_edge(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int gap;
        sif.din = '0; sif.dp_in = '0; sif.blank_in = '0; sif.upd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(sif.an), 32'hF);
        check("rst_seg", 32'(sif.seg), 32'h7F);
        check("rst_dp", 32'(sif.dp), 32'h1);
        check("rst_pending", 32'(sif.pending), 32'h0);
        reset = 1'b0;

        at_edge(1); check("guard0_an", 32'(sif.an), 32'hF);
        at_edge(1); check("guard1_an", 32'(sif.an), 32'hF);
        at_edge(1); check("slot0_an", 32'(sif.an), 32'hE);
        check("slot0_seg", 32'(sif.seg), 32'h40);
        at_edge(8); check("slot1_an", 32'(sif.an), 32'hD);
        at_edge(8); check("slot2_an", 32'(sif.an), 32'hB);
        at_edge(8); check("slot3_an", 32'(sif.an), 32'h7);

        wait_fs();
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!sif.frame_start && gap < 100);
        check("fs_period", 32'(gap), 32'd32);

        // Double buffer
        repeat (10) @(negedge clk);
        do_upd(16'h12AF, 4'h0, 4'h0);
        check("upd_pending", 32'(sif.pending), 32'h1);
        wait_fs();
        at_edge(1);
        check("db_dig0", 32'(sif.seg), 32'h0E);
        check("db_pending", 32'(sif.pending), 32'h0);
        at_edge(24); check("db_dig3", 32'(sif.seg), 32'h79);

        // Last wins, then boundary collision
        do_upd(16'h1111, 4'h0, 4'h0);
        do_upd(16'h2222, 4'h0, 4'h0);
        wait_fs();
        at_edge(1); check("lastwins_seg", 32'(sif.seg), 32'h24);
        wait_fs();
        repeat (FRAME - 1) @(negedge clk);
        sif.din = 16'h3333; sif.upd = 1'b1;
        @(negedge clk);
        sif.upd = 1'b0;
        check("coll_fs", 32'(sif.frame_start), 32'h1);
        check("coll_pending", 32'(sif.pending), 32'h0);
        at_edge(1); check("coll_seg", 32'(sif.seg), 32'h30);

        // Async reset in the middle of slot 2
        at_edge(21);
        check("pre_rst_an", 32'(sif.an), 32'hB);
        check("pre_rst_seg", 32'(sif.seg), 32'h30);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_an", 32'(sif.an), 32'hF);
        check("arst_seg", 32'(sif.seg), 32'h7F);
        @(negedge clk);
        reset = 1'b0;
        at_edge(3);
        check("restart_an", 32'(sif.an), 32'hE);
        check("restart_seg", 32'(sif.seg), 32'h40);

        // Blank and decimal point
        do_upd(16'h8888, 4'b0001, 4'b0100);
        sif.dp_in = '0; sif.blank_in = '0;
        wait_fs();
        at_edge(3);
        check("dp_slot0_an", 32'(sif.an), 32'hE);
        check("dp_slot0_dp", 32'(sif.dp), 32'h0);
        at_edge(8); check("dp_slot1_dp", 32'(sif.dp), 32'h1);
        at_edge(8);
        check("blank_slot2_an", 32'(sif.an), 32'hF);
        check("blank_slot2_seg", 32'(sif.seg), 32'h7F);

`ifdef SEG_SCAN_LZ_BLANK_EN
        do_upd(16'h0050, 4'h0, 4'h0);
        wait_fs();
        at_edge(3);  check("lz_d0_seg", 32'(sif.seg), 32'h40);
        at_edge(8);  check("lz_d1_seg", 32'(sif.seg), 32'h12);
        at_edge(8);  check("lz_d2_an", 32'(sif.an), 32'hF);
        at_edge(8);  check("lz_d3_an", 32'(sif.an), 32'hF);
        do_upd(16'h0000, 4'h0, 4'h0);
        wait_fs();
        at_edge(3);  check("lz0_d0_an", 32'(sif.an), 32'hE);
        at_edge(8);  check("lz0_d1_an", 32'(sif.an), 32'hF);
`endif

        // Random updates, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(11) == 0) begin
                sif.din      = 16'($urandom);
                sif.dp_in    = 4'($urandom);
                sif.blank_in = 4'($urandom);
                sif.upd      = 1'b1;
            end else begin
                sif.upd = 1'b0;
            end
        end
        @(negedge clk);
        sif.upd = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
